paddsb_seq: RTL and testbench
=============================

# paddsb_seq

Byte-serial sequencer for the packed saturating add/subtract instruction. It sits directly upstream of the 8-bit saturating adder stage in the execute path and captures two 16-bit operand words plus a subtract flag. It feeds one signed byte lane per cycle through a saturating add/sub datapath and collects the two lane results into a 16-bit result register. It presents that result, with per-lane saturation flags, to the downstream writeback/flag logic through a valid/ready handshake.

## Interface
- No parameters; lane width fixed at 8, word width fixed at 16.
- clk  input  1  rising-edge clock; one clock; reset is asynchronous and active-low.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  16  operand A, two signed bytes: lane0 = a[7:0], lane1 = a[15:8].
- b  input  16  operand B, same packing.
- sub  input  1  1 = compute A - B per lane; 0 = compute A + B.
- out_valid  output  1  result and flags valid; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- result  output  16  saturated lane results, lane0 in [7:0], lane1 in [15:8].
- sat  output  2  sat[i] = lane i saturated.
- zero  output  1  result == 16'h0000.
- busy  output  1  state is LO or HI.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, capture a, b, sub into internal registers, clear result/sat, go to LO.
  - LO: compute lane0, write result[7:0] and sat[0], go to HI.
  - HI: compute lane1, write result[15:8] and sat[1], go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE; otherwise hold.
- Lane arithmetic, using captured values only:
  - bb = sub ? ~b_lane : b_lane.
  - s = a_lane + bb + sub, 8-bit wrap.
  - Overflow when a_lane[7] == bb[7] and s[7] != a_lane[7].
  - On overflow the lane result is 8'h7F if a_lane[7]==0, else 8'h80, and sat[i]=1.
  - Otherwise the lane result is s and sat[i]=0.
  - Lane carries never propagate between lanes.
- Operand inputs that change after capture are ignored.
- in_valid while not in IDLE is ignored; in_ready is low, so no capture occurs.
- zero is combinational from the result register.
- result, sat and zero are only meaningful while out_valid=1. They hold their values in DONE under stall and after returning to IDLE, until the next capture clears them.
- sub in IDLE has no effect unless in_valid is high.

## Timing
- Reset, asynchronous, any state: state=IDLE; result=0; sat=0; captured operands=0; out_valid=0; busy=0; in_ready=1; zero=1.
- Reset mid-operation (LO/HI/DONE) aborts the operation. No out_valid is produced for the aborted operands.
- Acceptance edge E0 (IDLE, in_valid=1): busy=1 after E0.
- Edge E1: lane0 written.
- Edge E2: lane1 written; out_valid=1 and busy=0 after E2. Latency is 2 cycles from acceptance to out_valid.
- Transfer edge: out_valid & out_ready. After it, out_valid=0 and in_ready=1. A new operation is accepted at the earliest on the following edge.
- Minimum issue interval is 4 cycles with out_ready held high.
- out_ready low while in DONE: result/sat/out_valid stable for any number of cycles.
- in_ready and out_valid are never high in the same cycle.

## Test plan
- **Reset:** reset asserted mid-HI, then released -> out_valid=0, in_ready=1, result=0, zero=1. No spurious completion appears.
- **Plain add:**
  - Stimulus: a=16'h0310, b=16'h0225, sub=0, out_ready=1.
  - out_valid exactly 2 cycles after acceptance.
  - result=16'h0535, sat=0, zero=0.
- **Saturating add:** a=16'h807F, b=16'hFF01, sub=0.
  - Lane0 0x7F+0x01 -> 0x7F, sat[0]=1.
  - Lane1 0x80+0xFF -> 0x80, sat[1]=1.
  - result=16'h807F, sat=2'b11.
- **Subtract boundary:** a=16'h0005, b=16'h8005, sub=1.
  - Lane0 5-5=0x00, sat[0]=0.
  - Lane1 0-(-128) -> 0x7F, sat[1]=1.
  - result=16'h7F00, zero=0.
- **Stall and ignored inputs:**
  - Hold out_ready=0 for 5 cycles in DONE, and toggle a/b/in_valid during LO/HI/DONE.
  - result, sat and out_valid stay constant; in_ready=0 throughout; no second capture.
  - Raise out_ready -> IDLE next edge.
- **Back-to-back:** in_valid held high with two operand sets and out_ready=1 -> second acceptance exactly 4 cycles after the first; each result matches its own operands.

Source files
------------

// File: rtl/paddsb_seq.sv
// Byte-serial packed saturating add/sub: one signed byte lane per cycle, result after 2 cycles.
// Accepts only in IDLE (in_ready); holds result in DONE until out_ready, no internal buffering.
module paddsb_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [1:0]  sat,
    output logic        zero,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] a_q;
    logic [15:0] b_q;
    logic        sub_q;
    logic [15:0] result_q;
    logic [1:0]  sat_q;

    logic        capture;
    logic        wr_lo;
    logic        wr_hi;

    logic [7:0]  lane_a;
    logic [7:0]  lane_b;
    logic [7:0]  lane_bb;
    logic [7:0]  lane_sum;
    logic [7:0]  lane_res;
    logic        lane_ovf;

    // A single shared lane datapath; the state selects which byte it sees,
    // so carries can never cross from lane0 into lane1.
    always_comb begin
        lane_a   = (state == HI) ? a_q[15:8] : a_q[7:0];
        lane_b   = (state == HI) ? b_q[15:8] : b_q[7:0];
        lane_bb  = sub_q ? ~lane_b : lane_b;
        lane_sum = lane_a + lane_bb + {7'd0, sub_q};
        lane_ovf = (lane_a[7] == lane_bb[7]) && (lane_sum[7] != lane_a[7]);
        lane_res = lane_ovf ? (lane_a[7] ? 8'h80 : 8'h7F) : lane_sum;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        capture   = 1'b0;
        wr_lo     = 1'b0;
        wr_hi     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture   = 1'b1;
                    state_nxt = LO;
                end
            end
            LO: begin
                busy      = 1'b1;
                wr_lo     = 1'b1;
                state_nxt = HI;
            end
            HI: begin
                busy      = 1'b1;
                wr_hi     = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            sub_q    <= 1'b0;
            result_q <= 16'h0000;
            sat_q    <= 2'b00;
        end else begin
            if (capture) begin
                a_q      <= a;
                b_q      <= b;
                sub_q    <= sub;
                result_q <= 16'h0000;
                sat_q    <= 2'b00;
            end
            if (wr_lo) begin
                result_q[7:0] <= lane_res;
                sat_q[0]      <= lane_ovf;
            end
            if (wr_hi) begin
                result_q[15:8] <= lane_res;
                sat_q[1]       <= lane_ovf;
            end
        end
    end

    assign result = result_q;
    assign sat    = sat_q;
    assign zero   = (result_q == 16'h0000);

endmodule

// File: tb/tb_paddsb_seq.sv
// Directed bench for paddsb_seq: hand-computed lane results, latency, stall, reset abort, back-to-back issue.
module tb_paddsb_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [1:0]  sat;
    logic        zero;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    paddsb_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sat       (sat),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE, measure latency, check outputs, then transfer.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                         input logic ts, input logic [15:0] er, input logic [1:0] es);
        int lat;
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_;
        sub       = ts;
        out_ready = 1'b1;
        chk({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
        edge1();
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb_;
        sub      = ~ts;
        chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
        lat = 0;
        while (!out_valid && lat < 10) begin
            edge1();
            lat++;
        end
        chk({tag, "_latency"}, lat[15:0], 16'd2);
        chk({tag, "_result"}, result, er);
        chk({tag, "_sat"}, {14'd0, sat}, {14'd0, es});
        chk({tag, "_zero"}, {15'd0, zero}, {15'd0, (er == 16'h0000)});
        chk({tag, "_nobusy"}, {15'd0, busy}, 16'd0);
        edge1();
        chk({tag, "_xfer_ov"}, {15'd0, out_valid}, 16'd0);
        chk({tag, "_xfer_ir"}, {15'd0, in_ready}, 16'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        sub       = 1'b0;
        out_ready = 1'b0;
        #12;
        // reset state
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_result", result, 16'h0000);
        chk("rst_zero", {15'd0, zero}, 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        edge1();

        do_op("add",    16'h0310, 16'h0225, 1'b0, 16'h0535, 2'b00);
        do_op("satadd", 16'h807F, 16'hFF01, 1'b0, 16'h807F, 2'b11);
        do_op("subbnd", 16'h0005, 16'h8005, 1'b1, 16'h7F00, 2'b10);
        do_op("subzero", 16'h1234, 16'h1234, 1'b1, 16'h0000, 2'b00);
        do_op("negsat", 16'h8080, 16'h8080, 1'b0, 16'h8080, 2'b11);
        do_op("subneg", 16'h7F80, 16'h0101, 1'b1, 16'h7E80, 2'b01);

        // reset asserted in HI aborts the operation
        in_valid  = 1'b1;
        a         = 16'h1111;
        b         = 16'h2222;
        sub       = 1'b0;
        out_ready = 1'b1;
        edge1();
        in_valid = 1'b0;
        edge1();
        chk("hi_busy", {15'd0, busy}, 16'd1);
        chk("hi_lane0", {8'd0, result[7:0]}, 16'h0033);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("arst_in_ready", {15'd0, in_ready}, 16'd1);
        chk("arst_result", result, 16'h0000);
        chk("arst_zero", {15'd0, zero}, 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edge1();
            chk("arst_no_completion", {15'd0, out_valid}, 16'd0);
        end

        // stall in DONE while inputs toggle
        in_valid  = 1'b1;
        a         = 16'h1234;
        b         = 16'h0101;
        sub       = 1'b0;
        out_ready = 1'b0;
        edge1();
        for (int i = 0; i < 2; i++) begin
            a   = 16'hA5A5 ^ 16'(i);
            b   = 16'h5A5A;
            sub = 1'b1;
            in_valid = ~in_valid;
            chk("stall_busy_ir", {15'd0, in_ready}, 16'd0);
            edge1();
        end
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 16'h0F0F + 16'(i);
            chk("stall_out_valid", {15'd0, out_valid}, 16'd1);
            chk("stall_in_ready", {15'd0, in_ready}, 16'd0);
            chk("stall_result", result, 16'h1335);
            chk("stall_sat", {14'd0, sat}, 16'd0);
            edge1();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        edge1();
        chk("stall_release_ov", {15'd0, out_valid}, 16'd0);
        chk("stall_release_ir", {15'd0, in_ready}, 16'd1);
        chk("stall_release_busy", {15'd0, busy}, 16'd0);
        chk("stall_hold_result", result, 16'h1335);

        // back-to-back with in_valid held high
        in_valid  = 1'b1;
        a         = 16'h0110;
        b         = 16'h0220;
        sub       = 1'b0;
        out_ready = 1'b1;
        edge1();
        chk("b2b_acc1", {15'd0, busy}, 16'd1);
        a   = 16'h7F80;
        b   = 16'h0101;
        sub = 1'b1;
        edge1();
        edge1();
        chk("b2b_res1_ov", {15'd0, out_valid}, 16'd1);
        chk("b2b_res1", result, 16'h0330);
        chk("b2b_sat1", {14'd0, sat}, 16'd0);
        edge1();
        chk("b2b_idle_ir", {15'd0, in_ready}, 16'd1);
        chk("b2b_idle_ov", {15'd0, out_valid}, 16'd0);
        edge1();
        chk("b2b_acc2", {15'd0, busy}, 16'd1);
        in_valid = 1'b0;
        edge1();
        edge1();
        chk("b2b_res2_ov", {15'd0, out_valid}, 16'd1);
        chk("b2b_res2", result, 16'h7E80);
        chk("b2b_sat2", {14'd0, sat}, 16'd1);
        edge1();
        chk("b2b_end_ir", {15'd0, in_ready}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
